// File: rtl/pkt_meta_out_sched_pkg.sv
// rtl/pkt_meta_out_sched_pkg.sv - shared widths, beat tags, metadata offsets and FSM encoding
package pkt_meta_out_sched_pkg;

  localparam int PKT_W         = 134;
  localparam int META_W        = 128;
  localparam int MAX_BEATS_DEF = 128;
  localparam int META_LEN_LSB  = 0;
  localparam int META_DROP_BIT = 127;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META_WAIT,
    ST_STREAM,
    ST_DROP
  } pms_state_t;

  // 16B beats needed for a byte length; 17 bits so an oversize length stays visible
  function automatic logic [16:0] beats_from_len(input logic [15:0] len);
    return ({1'b0, len} + 17'd15) >> 4;
  endfunction

endpackage

// File: rtl/pkt_meta_out_sched_skid.sv
// rtl/pkt_meta_out_sched_skid.sv - one-entry bypass skid register for packet beats
module pms_skid_reg
  import pkt_meta_out_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] up_tdata,
  input  logic             up_tvalid,
  output logic             up_tready,
  output logic [PKT_W-1:0] dn_tdata,
  output logic             dn_tvalid,
  input  logic             dn_tready
);

  logic             full;
  logic [PKT_W-1:0] hold_q;

  // a beat only lands here when downstream refuses it on arrival
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      hold_q <= '0;
    end else if (full) begin
      if (dn_tready) full <= 1'b0;
    end else if (up_tvalid && !dn_tready) begin
      full   <= 1'b1;
      hold_q <= up_tdata;
    end
  end

  assign up_tready = !full;
  assign dn_tvalid = full || up_tvalid;
  assign dn_tdata  = full ? hold_q : up_tdata;

endmodule

// File: rtl/pkt_meta_out_sched.sv
// rtl/pkt_meta_out_sched.sv - pops one metadata entry, then streams or drops exactly that packet's beats
module pkt_meta_out_sched
  import pkt_meta_out_sched_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int LEN_LSB   = META_LEN_LSB,
  parameter int DROP_BIT  = META_DROP_BIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_empty_meta,
  output logic              o_rden_meta,
  input  logic [META_W-1:0] i_dout_meta,
  input  logic              i_empty_pkt,
  output logic              o_rden_pkt,
  input  logic [PKT_W-1:0]  i_dout_pkt,
  input  logic              i_ready,
  output logic              o_pkt_valid,
  output logic [PKT_W-1:0]  o_pkt,
  output logic [META_W-1:0] o_meta,
  output logic              o_meta_valid,
  output logic              o_err,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_drop_cnt
);

  localparam int               CNT_W         = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT       = CNT_W'(MAX_BEATS);
  localparam logic [16:0]      MAX_LEN_BEATS = 17'(MAX_BEATS);

  pms_state_t       state;
  logic [CNT_W-1:0] remaining;
  logic             ret, ret_last, first_ret, first_out;
  logic             skid_ready, dn_tvalid;
  logic [PKT_W-1:0] dn_tdata;
  logic [15:0]      meta_len;
  logic [16:0]      beats_raw;
  logic             len_bad;
  logic [CNT_W-1:0] beats_ld;
  logic             rden_pkt, rden_meta, accept, stream_done, drop_done, tag_ok;
  logic [1:0]       ret_tag;

  assign meta_len  = i_dout_meta[LEN_LSB +: 16];
  assign beats_raw = beats_from_len(meta_len);
  assign len_bad   = (meta_len == 16'd0) || (beats_raw > MAX_LEN_BEATS);

  always_comb begin
    beats_ld = beats_raw[CNT_W-1:0];
    if (meta_len == 16'd0)               beats_ld = CNT_W'(1);
    else if (beats_raw > MAX_LEN_BEATS)  beats_ld = MAX_CNT;
  end

  always_comb begin
    rden_pkt = 1'b0;
    if (state == ST_STREAM)
      rden_pkt = (remaining != '0) && !i_empty_pkt && i_ready && skid_ready;
    else if (state == ST_DROP)
      rden_pkt = (remaining != '0) && !i_empty_pkt;
  end

  // at most one beat is ever in flight, so a presented beat with nothing left to read is the tail
  assign accept      = dn_tvalid && i_ready;
  assign stream_done = (state == ST_STREAM) && (remaining == '0) && accept;
  assign drop_done   = (state == ST_DROP) && (remaining == '0) && ret;
  assign rden_meta   = !i_rst && !i_empty_meta && ((state == ST_IDLE) || stream_done);

  assign ret_tag = i_dout_pkt[PKT_W-1 -: 2];

  always_comb begin
    tag_ok = 1'b1;
    if (first_ret && ret_last) tag_ok = ret_tag[0];
    else if (first_ret)        tag_ok = (ret_tag == TAG_HEAD);
    else if (ret_last)         tag_ok = (ret_tag == TAG_TAIL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      ret        <= 1'b0;
      ret_last   <= 1'b0;
      first_ret  <= 1'b0;
      first_out  <= 1'b0;
      o_meta     <= '0;
      o_err      <= 1'b0;
      o_pkt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      ret      <= rden_pkt;
      ret_last <= rden_pkt && (remaining == CNT_W'(1));
      if (rden_pkt) remaining <= remaining - CNT_W'(1);
      if (ret && (state == ST_STREAM || state == ST_DROP)) begin
        first_ret <= 1'b0;
        if (!tag_ok) o_err <= 1'b1;
      end
      if (o_meta_valid) first_out <= 1'b0;
      if (stream_done)  o_pkt_cnt  <= o_pkt_cnt + 32'd1;
      if (drop_done)    o_drop_cnt <= o_drop_cnt + 32'd1;

      case (state)
        ST_IDLE: if (rden_meta) state <= ST_META_WAIT;
        ST_META_WAIT: begin
          o_meta    <= i_dout_meta;
          remaining <= beats_ld;
          first_ret <= 1'b1;
          first_out <= 1'b1;
          if (len_bad) o_err <= 1'b1;
          state <= i_dout_meta[DROP_BIT] ? ST_DROP : ST_STREAM;
        end
        ST_STREAM: if (stream_done) state <= rden_meta ? ST_META_WAIT : ST_IDLE;
        ST_DROP:   if (drop_done) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  pms_skid_reg u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .up_tdata  (i_dout_pkt),
    .up_tvalid (ret && (state == ST_STREAM)),
    .up_tready (skid_ready),
    .dn_tdata  (dn_tdata),
    .dn_tvalid (dn_tvalid),
    .dn_tready (i_ready)
  );

  assign o_rden_meta  = rden_meta;
  assign o_rden_pkt   = rden_pkt;
  assign o_pkt_valid  = dn_tvalid;
  assign o_pkt        = dn_tvalid ? dn_tdata : '0;
  assign o_meta_valid = (state == ST_STREAM) && first_out && accept;

endmodule
